// File: rtl/random_reaction_timer.sv
// Reaction-game timer: waits a pseudo-random delay after start, raises a stimulus,
// then measures the cycles until respond, flagging false starts and honouring abort.
module random_reaction_timer #(
    parameter int LFSR_W      = 16,
    parameter int SEED        = 1,
    parameter int RAND_BITS   = 8,
    parameter int DELAY_SHIFT = 4,
    parameter int MIN_DELAY   = 1000,
    parameter int CNT_W       = 24,
    parameter int RT_W        = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            respond,
    input  logic            abort,
    input  logic            repeat_mode,
    output logic            stim,
    output logic            tick,
    output logic            busy,
    output logic            early,
    output logic            rt_valid,
    output logic [RT_W-1:0] rt,
    output logic            rt_sat
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_STIM = 2'd2;

    localparam logic [LFSR_W-1:0] SEED_T   = LFSR_W'(SEED);
    localparam logic [LFSR_W-1:0] SEED_EFF = (SEED_T == '0) ? LFSR_W'(1) : SEED_T;
    localparam logic [63:0]       CNT_MAX  = (64'd1 << CNT_W) - 64'd1;
    localparam logic [RT_W-1:0]   RT_MAX   = '1;

    logic [1:0]        state_reg;
    logic [LFSR_W-1:0] lfsr_reg;
    logic [LFSR_W-1:0] lfsr_next;
    logic              fb;
    logic [CNT_W-1:0]  cnt_reg;
    logic [CNT_W-1:0]  tgt_m1_reg;
    logic [CNT_W-1:0]  tgt_m1_next;
    logic [RT_W-1:0]   rtc_reg;
    logic [RT_W-1:0]   rt_reg;
    logic              tick_reg;
    logic              early_reg;
    logic              rt_valid_reg;
    logic              rt_sat_reg;
    logic [63:0]       delay_wide;

    generate
        if (LFSR_W == 8) begin : g_tap8
            assign fb = lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3];
        end else if (LFSR_W == 16) begin : g_tap16
            assign fb = lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10];
        end else if (LFSR_W == 24) begin : g_tap24
            assign fb = lfsr_reg[23] ^ lfsr_reg[22] ^ lfsr_reg[21] ^ lfsr_reg[16];
        end else begin : g_tap32
            assign fb = lfsr_reg[31] ^ lfsr_reg[21] ^ lfsr_reg[1] ^ lfsr_reg[0];
        end
    endgenerate

    assign lfsr_next = {lfsr_reg[LFSR_W-2:0], fb};

    // The counter runs from 0, so the WAIT exit compare is against target-1.
    assign delay_wide  = 64'(MIN_DELAY) + (64'(lfsr_reg[RAND_BITS-1:0]) << DELAY_SHIFT);
    assign tgt_m1_next = (delay_wide > CNT_MAX) ? CNT_W'(CNT_MAX - 64'd1)
                                                : CNT_W'(delay_wide - 64'd1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= ST_IDLE;
            lfsr_reg     <= SEED_EFF;
            cnt_reg      <= '0;
            tgt_m1_reg   <= '0;
            rtc_reg      <= '0;
            rt_reg       <= '0;
            tick_reg     <= 1'b0;
            early_reg    <= 1'b0;
            rt_valid_reg <= 1'b0;
            rt_sat_reg   <= 1'b0;
        end else begin
            lfsr_reg     <= lfsr_next;
            tick_reg     <= 1'b0;
            rt_valid_reg <= 1'b0;
            if (abort) begin
                state_reg <= ST_IDLE;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (start) begin
                            tgt_m1_reg <= tgt_m1_next;
                            cnt_reg    <= '0;
                            early_reg  <= 1'b0;
                            state_reg  <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                        if (respond) begin
                            early_reg <= 1'b1;
                            state_reg <= ST_IDLE;
                        end else if (cnt_reg == tgt_m1_reg) begin
                            state_reg <= ST_STIM;
                            tick_reg  <= 1'b1;
                            rtc_reg   <= '0;
                        end
                    end
                    ST_STIM: begin
                        if (respond) begin
                            rt_reg       <= rtc_reg;
                            rt_sat_reg   <= (rtc_reg == RT_MAX);
                            rt_valid_reg <= 1'b1;
                            if (repeat_mode) begin
                                tgt_m1_reg <= tgt_m1_next;
                                cnt_reg    <= '0;
                                state_reg  <= ST_WAIT;
                            end else begin
                                state_reg <= ST_IDLE;
                            end
                        end else if (rtc_reg != RT_MAX) begin
                            rtc_reg <= rtc_reg + RT_W'(1);
                        end
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

    assign stim     = (state_reg == ST_STIM);
    assign busy     = (state_reg == ST_WAIT) || (state_reg == ST_STIM);
    assign tick     = tick_reg;
    assign early    = early_reg;
    assign rt_valid = rt_valid_reg;
    assign rt       = rt_reg;
    assign rt_sat   = rt_sat_reg;

endmodule

// File: tb/tb_random_reaction_timer.sv
// Scoreboard bench for random_reaction_timer: expected tick edges and reaction
// times are queued when stimulus is driven and compared when the DUT reports them.
module tb_random_reaction_timer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       respond = 1'b0;
    logic       abort = 1'b0;
    logic       repeat_mode = 1'b0;
    logic       stim, tick, busy, early, rt_valid, rt_sat;
    logic [3:0] rt;

    logic       start_s = 1'b0;
    logic       zero_in = 1'b0;
    logic       stim_s, tick_s, busy_s, early_s, rt_valid_s, rt_sat_s;
    logic [3:0] rt_s;

    int   n_checks = 0;
    int   n_errors = 0;
    int   edge_cnt = 0;
    int   exp_tick_q[$];
    int   exp_rt_q[$];
    int   last_tick_edge = 0;
    int   exp_tick_s = -1;
    logic seen_s = 1'b0;
    logic [7:0] m_lfsr;

    random_reaction_timer #(
        .LFSR_W(8), .SEED(1), .RAND_BITS(4), .DELAY_SHIFT(2),
        .MIN_DELAY(5), .CNT_W(12), .RT_W(4)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .respond(respond), .abort(abort),
        .repeat_mode(repeat_mode), .stim(stim), .tick(tick), .busy(busy),
        .early(early), .rt_valid(rt_valid), .rt(rt), .rt_sat(rt_sat)
    );

    // Narrow delay counter so the target saturates to 15.
    random_reaction_timer #(
        .LFSR_W(8), .SEED(1), .RAND_BITS(4), .DELAY_SHIFT(2),
        .MIN_DELAY(14), .CNT_W(4), .RT_W(4)
    ) dut_sat (
        .clk(clk), .rst(rst), .start(start_s), .respond(zero_in), .abort(zero_in),
        .repeat_mode(zero_in), .stim(stim_s), .tick(tick_s), .busy(busy_s),
        .early(early_s), .rt_valid(rt_valid_s), .rt(rt_s), .rt_sat(rt_sat_s)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Reference LFSR used to predict the delay of each accepted start.
    always @(posedge clk or negedge rst) begin
        if (!rst) m_lfsr <= 8'h01;
        else      m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end else begin
            $display("ok   %s: %0d (t=%0t)", tag, obs, $time);
        end
    endtask

    function automatic int exp_target(input logic [7:0] lf, input int min_d, input int cmax);
        int t;
        t = min_d + (int'(lf[3:0]) << 2);
        if (t > cmax) t = cmax;
        return t;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            if (tick) begin
                if (exp_tick_q.size() == 0) check("tick_unexpected", tick, 0);
                else check("tick_edge", edge_cnt, exp_tick_q.pop_front());
                check("tick_stim", stim, 1);
            end
            if (rt_valid) begin
                if (exp_rt_q.size() == 0) begin
                    check("rt_valid_unexpected", rt_valid, 0);
                end else begin
                    int e;
                    e = exp_rt_q.pop_front();
                    check("rt", rt, e & 15);
                    check("rt_sat", rt_sat, e >> 4);
                end
            end
            if (tick_s) begin
                check("sat_tick_edge", edge_cnt, exp_tick_s);
                seen_s = 1'b1;
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_stim"}, stim, 0);
        check({tag, "_tick"}, tick, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_early"}, early, 0);
        check({tag, "_rt_valid"}, rt_valid, 0);
        check({tag, "_rt"}, rt, 0);
        check({tag, "_rt_sat"}, rt_sat, 0);
    endtask

    task automatic push_tick();
        last_tick_edge = edge_cnt + 1 + exp_target(m_lfsr, 5, 4095);
        exp_tick_q.push_back(last_tick_edge);
    endtask

    task automatic start_trial(input bit expect_tick);
        step();
        start = 1'b1;
        if (expect_tick) push_tick();
        step();
        start = 1'b0;
        check("start_busy", busy, 1);
        check("start_early_clr", early, 0);
    endtask

    task automatic wait_tick();
        int n;
        n = 0;
        while (!tick && n < 100) begin
            check("busy_wait", busy, 1);
            step();
            n++;
        end
        check("tick_seen", tick, 1);
    endtask

    task automatic do_respond(input int wait_n, input bit rep, output int exp_rt);
        int raw;
        for (int k = 0; k < wait_n; k++) begin
            step();
            if (k == 0) check("tick_width", tick, 0);
        end
        raw    = edge_cnt - last_tick_edge;
        exp_rt = (raw >= 15) ? 15 : raw;
        exp_rt_q.push_back(exp_rt | ((raw >= 15) ? 16 : 0));
        if (rep) push_tick();
        respond = 1'b1;
        step();
        respond = 1'b0;
        check("resp_stim_low", stim, 0);
        check("resp_busy", busy, rep ? 1 : 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        int rt_prev;
        logic [7:0] seq [7];
        seq = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47};

        // 1: reset state, start sampled at the first edge after release
        start   = 1'b1;
        start_s = 1'b1;
        #3;
        check_reset_outputs("reset");
        step();
        rst = 1'b1;
        push_tick();
        exp_tick_s = edge_cnt + 1 + exp_target(m_lfsr, 14, 15);
        step();
        start   = 1'b0;
        start_s = 1'b0;
        check("t1_busy", busy, 1);
        wait_tick();

        // 2: respond three cycles into STIM
        do_respond(3, 1'b0, r);
        check("t2_rt_value", rt, 3);
        step();
        check("t2_rt_valid_pulse", rt_valid, 0);

        // 3: false start during WAIT, then next start clears early
        start_trial(1'b0);
        for (int k = 0; k < 3; k++) step();
        respond = 1'b1;
        step();
        respond = 1'b0;
        check("t3_early", early, 1);
        check("t3_busy", busy, 0);
        for (int k = 0; k < 4; k++) step();
        check("t3_early_sticky", early, 1);
        start_trial(1'b1);

        // 4: reaction time saturates
        wait_tick();
        do_respond(20, 1'b0, r);
        check("t4_rt_value", rt, 15);
        check("t4_sat_seen", seen_s, 1);
        check("t4_sat_stim_hold", stim_s, 1);

        // 5: auto-repeat, then abort together with respond
        repeat_mode = 1'b1;
        start_trial(1'b1);
        wait_tick();
        do_respond(2, 1'b1, rt_prev);
        check("t5_rearm_wait", busy, 1);
        wait_tick();
        step();
        abort   = 1'b1;
        respond = 1'b1;
        step();
        abort   = 1'b0;
        respond = 1'b0;
        repeat_mode = 1'b0;
        check("t5_abort_busy", busy, 0);
        check("t5_abort_stim", stim, 0);
        check("t5_abort_rt", rt, rt_prev);
        step();
        step();

        // 6: asynchronous reset mid-WAIT and mid-STIM
        start_trial(1'b0);
        step();
        #2 rst = 1'b0;
        #1 check_reset_outputs("rst_wait");
        step();
        rst = 1'b1;
        start_trial(1'b1);
        wait_tick();
        step();
        step();
        #2 rst = 1'b0;
        #1 check_reset_outputs("rst_stim");
        check("lfsr_0", dut.lfsr_reg, seq[0]);
        step();
        rst = 1'b1;
        for (int i = 1; i < 7; i++) begin
            step();
            check($sformatf("lfsr_%0d", i), dut.lfsr_reg, seq[i]);
        end

        check("sb_tick_drain", exp_tick_q.size(), 0);
        check("sb_rt_drain", exp_rt_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
